// File: rtl/mux41_pkg.sv
// Shared constants for the 4:1 mux round-robin arbiter.
package mux41_pkg;

  localparam int NREQ = 4;

  // FSM state encoding
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  // Requester index to mux select mapping
  localparam logic [1:0] IDX_A = 2'd0;
  localparam logic [1:0] IDX_B = 2'd1;
  localparam logic [1:0] IDX_C = 2'd2;
  localparam logic [1:0] IDX_D = 2'd3;

  // Index to one-hot grant
  function automatic logic [NREQ-1:0] onehot4(input logic [1:0] idx);
    logic [NREQ-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first set request scanning upward
// from ptr with wrap-around.
module rr_pick4
  import mux41_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      ptr,
  output logic [1:0]      winner,
  output logic            any
);

  // Scan ptr, ptr+1, ... and stop at the first set bit
  always_comb begin
    logic       found;
    logic [1:0] idx;
    winner = ptr;
    found  = 1'b0;
    idx    = ptr;
    for (int i = 0; i < NREQ; i++) begin
      idx = ptr + 2'(i);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
    any = found;
  end

endmodule

// File: rtl/mux41_rr_arbiter.sv
// Round-robin arbiter in front of a 4:1 mux. Registered one-hot grant and
// select; a hold counter forces rotation when others are waiting.
module mux41_rr_arbiter
  import mux41_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant,
  output logic            Sel0,
  output logic            Sel1,
  output logic            busy
);

  logic [0:0]       state;
  logic [1:0]       last;
  logic [1:0]       sel;
  logic [CNT_W-1:0] cnt;

  logic [1:0] ptr;
  logic [1:0] winner;
  logic       any;
  logic       others;
  logic       hold_done;

  assign Sel0 = sel[0];
  assign Sel1 = sel[1];

  // While granting, sel is the holder index, so the scan starts just after it
  // and the holder itself is considered last.
  assign ptr       = (state == ST_GRANT) ? sel + 2'd1 : last + 2'd1;
  assign others    = |(req & ~grant);
  assign hold_done = (cnt == CNT_W'(MAX_HOLD - 1));

  rr_pick4 u_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (winner),
    .any    (any)
  );

  // Arbitration FSM; grant, select and busy always move together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      last  <= IDX_D;
      sel   <= IDX_A;
      grant <= '0;
      busy  <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any) begin
            grant <= onehot4(winner);
            sel   <= winner;
            last  <= winner;
            busy  <= 1'b1;
            cnt   <= '0;
            state <= ST_GRANT;
          end
        end
        default: begin
          if (!req[sel]) begin
            cnt <= '0;
            if (others) begin
              grant <= onehot4(winner);
              sel   <= winner;
              last  <= winner;
            end else begin
              grant <= '0;
              busy  <= 1'b0;
              state <= ST_IDLE;
            end
          end else if (hold_done) begin
            cnt <= '0;
            if (others) begin
              grant <= onehot4(winner);
              sel   <= winner;
              last  <= winner;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

endmodule
